// File: rtl/banked_reg_file.sv
// ============================================================================
//  Module      : banked_reg_file
//  Description : Multi-bank register file with write-to-read bypass, a
//                per-register pending scoreboard and a per-bank clear sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module banked_reg_file #(
    parameter  int XLEN    = 32,
    parameter  int NREG    = 32,
    parameter  int NBANK   = 2,
    parameter  int NRD     = 2,
    parameter  int NWR     = 1,
    parameter  int SP_REG  = 2,
    parameter  int SP_INIT = 256,
    localparam int c_AW    = $clog2(NREG),
    localparam int c_BW    = (NBANK > 1) ? $clog2(NBANK) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NRD*c_AW-1:0]  ra,
    input  logic [NRD*c_BW-1:0]  rbank,
    output logic [NRD*XLEN-1:0]  rd,
    output logic [NRD-1:0]       pend,
    input  logic [NWR-1:0]       wen,
    input  logic [NWR*c_AW-1:0]  wa,
    input  logic [NWR*c_BW-1:0]  wbank,
    input  logic [NWR*XLEN-1:0]  wd,
    input  logic                 rsv_en,
    input  logic [c_AW-1:0]      rsv_addr,
    input  logic [c_BW-1:0]      rsv_bank,
    input  logic                 clr_req,
    input  logic [c_BW-1:0]      clr_bank,
    output logic                 clr_busy,
    output logic                 clr_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [XLEN-1:0] r_mem  [NBANK][NREG];
    logic            r_pend [NBANK][NREG];
    logic [1:0]      r_state;
    logic [c_BW-1:0] r_clrBank;
    logic [c_AW-1:0] r_cnt;

    logic            w_busy;
    logic [c_AW-1:0] w_wa [NWR];
    logic [c_BW-1:0] w_wb [NWR];
    logic [XLEN-1:0] w_wd [NWR];
    logic [NWR-1:0]  w_wValid;
    logic            w_rsvValid;

    function automatic logic [XLEN-1:0] f_rstVal(input int b, input int r);
        return (b == 0 && r == SP_REG) ? XLEN'(SP_INIT) : '0;
    endfunction

    function automatic logic f_bankOk(input logic [c_BW-1:0] b);
        return int'(b) < NBANK;
    endfunction

    assign w_busy   = (r_state != S_IDLE);
    assign clr_busy = w_busy;
    assign clr_done = (r_state == S_DONE);

    // A write/reserve is dropped for bank0 r0 and for the bank being cleared
    for (genvar j = 0; j < NWR; j++) begin : g_wr
        assign w_wa[j] = wa[j*c_AW +: c_AW];
        assign w_wb[j] = wbank[j*c_BW +: c_BW];
        assign w_wd[j] = wd[j*XLEN +: XLEN];
        assign w_wValid[j] = wen[j] && f_bankOk(w_wb[j])
                          && !((w_wb[j] == '0) && (w_wa[j] == '0))
                          && !(w_busy && (w_wb[j] == r_clrBank));
    end

    assign w_rsvValid = rsv_en && f_bankOk(rsv_bank)
                     && !((rsv_bank == '0) && (rsv_addr == '0))
                     && !(w_busy && (rsv_bank == r_clrBank));

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [c_AW-1:0] w_ra;
        logic [c_BW-1:0] w_rb;
        logic [XLEN-1:0] w_data;
        logic            w_p;

        assign w_ra = ra[i*c_AW +: c_AW];
        assign w_rb = rbank[i*c_BW +: c_BW];

        always_comb begin
            w_data = '0;
            w_p    = 1'b0;
            if (f_bankOk(w_rb)) begin
                if (w_busy && (w_rb == r_clrBank)) begin
                    w_data = f_rstVal(int'(w_rb), int'(w_ra));
                end else if (!((w_rb == '0) && (w_ra == '0))) begin
                    w_data = r_mem[w_rb][w_ra];
                    w_p    = r_pend[w_rb][w_ra];
                    // Highest-index matching write port has the final say
                    for (int j = 0; j < NWR; j++) begin
                        if (w_wValid[j] && (w_wb[j] == w_rb) && (w_wa[j] == w_ra)) begin
                            w_data = w_wd[j];
                            w_p    = 1'b0;
                        end
                    end
                end
            end
        end

        assign rd[i*XLEN +: XLEN] = w_data;
        assign pend[i]            = w_p;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < NBANK; b++) begin
                for (int r = 0; r < NREG; r++) begin
                    r_mem[b][r]  <= f_rstVal(b, r);
                    r_pend[b][r] <= 1'b0;
                end
            end
            r_state   <= S_IDLE;
            r_clrBank <= '0;
            r_cnt     <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (w_wValid[j]) begin
                    r_mem[w_wb[j]][w_wa[j]]  <= w_wd[j];
                    r_pend[w_wb[j]][w_wa[j]] <= 1'b0;
                end
            end
            // Issued after the write clears so a same-cycle reservation sticks
            if (w_rsvValid) begin
                r_pend[rsv_bank][rsv_addr] <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (clr_req && f_bankOk(clr_bank)) begin
                        r_state   <= S_CLEAR;
                        r_clrBank <= clr_bank;
                        r_cnt     <= '0;
                    end
                end
                S_CLEAR: begin
                    r_mem[r_clrBank][r_cnt]  <= f_rstVal(int'(r_clrBank), int'(r_cnt));
                    r_pend[r_clrBank][r_cnt] <= 1'b0;
                    r_cnt                    <= r_cnt + 1'b1;
                    if (r_cnt == c_AW'(NREG - 1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_banked_reg_file.sv
// ============================================================================
//  Module      : tb_banked_reg_file
//  Description : Self-checking bench for banked_reg_file (NWR=2, NRD=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_banked_reg_file;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NBANK = 2;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;
    localparam int BW    = 1;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*BW-1:0]   rbank;
    logic [NRD*XLEN-1:0] rd;
    logic [NRD-1:0]      pend;
    logic [NWR-1:0]      wen;
    logic [NWR*AW-1:0]   wa;
    logic [NWR*BW-1:0]   wbank;
    logic [NWR*XLEN-1:0] wd;
    logic                rsv_en;
    logic [AW-1:0]       rsv_addr;
    logic [BW-1:0]       rsv_bank;
    logic                clr_req;
    logic [BW-1:0]       clr_bank;
    logic                clr_busy;
    logic                clr_done;

    int checks = 0;
    int errors = 0;

    banked_reg_file #(
        .XLEN(XLEN), .NREG(NREG), .NBANK(NBANK), .NRD(NRD), .NWR(NWR),
        .SP_REG(2), .SP_INIT(256)
    ) dut (
        .clock(clock), .reset(reset),
        .ra(ra), .rbank(rbank), .rd(rd), .pend(pend),
        .wen(wen), .wa(wa), .wbank(wbank), .wd(wd),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_bank(rsv_bank),
        .clr_req(clr_req), .clr_bank(clr_bank),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;   // 0 = read data, 1 = pending bit
        int          port;
        logic [31:0] exp;
        string       name;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit we0; int wb0; int wa0; logic [31:0] wd0;
        bit we1; int wb1; int wa1; logic [31:0] wd1;
        bit rsv; int rsb; int rsa;
        int rb0; int ra0; int rb1; int ra1;
        logic [31:0] e0; logic [31:0] e1; bit p0; bit p1;
        string name;
    } vec_t;
    vec_t tbl[16];

    task automatic idle();
        wen = '0; wa = '0; wbank = '0; wd = '0;
        rsv_en = 1'b0; rsv_addr = '0; rsv_bank = '0;
        clr_req = 1'b0; clr_bank = '0;
        ra = '0; rbank = '0;
    endtask

    task automatic setRd(input int p, input int b, input int a);
        rbank[p*BW +: BW] = BW'(b);
        ra[p*AW +: AW]    = AW'(a);
    endtask

    task automatic setWr(input int p, input int b, input int a, input logic [31:0] d);
        wen[p]              = 1'b1;
        wbank[p*BW +: BW]   = BW'(b);
        wa[p*AW +: AW]      = AW'(a);
        wd[p*XLEN +: XLEN]  = d;
    endtask

    task automatic setRsv(input int b, input int a);
        rsv_en   = 1'b1;
        rsv_bank = BW'(b);
        rsv_addr = AW'(a);
    endtask

    task automatic expRd(input int p, input logic [31:0] v, input string n);
        exp_t e;
        e.kind = 0; e.port = p; e.exp = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic expPend(input int p, input logic v, input string n);
        exp_t e;
        e.kind = 1; e.port = p; e.exp = {31'b0, v}; e.name = n;
        sb.push_back(e);
    endtask

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", n, act, exp);
        end
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.kind == 0) act = rd[e.port*XLEN +: XLEN];
            else             act = {31'b0, pend[e.port]};
            check(e.name, act, e.exp);
        end
    endtask

    // Sample 1 ns before the rising edge, then advance to the next falling edge
    task automatic step();
        #4;
        drain();
        @(posedge clock);
        @(negedge clock);
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int busyCnt;
        int doneCnt;
        vec_t v;

        //            we0 wb0 wa0 wd0           we1 wb1 wa1 wd1   rsv rsb rsa  rb0 ra0 rb1 ra1  e0            e1            p0 p1
        tbl[0]  = '{0,0,0,32'h0,          0,0,0,32'h0,  0,0,0,  0,2,1,2,  32'd256,      32'h0,        0,0, "reset_sp"};
        tbl[1]  = '{1,0,0,32'h5,          0,0,0,32'h0,  0,0,0,  0,0,0,0,  32'h0,        32'h0,        0,0, "r0_write_bypass"};
        tbl[2]  = '{0,0,0,32'h0,          0,0,0,32'h0,  0,0,0,  0,0,1,0,  32'h0,        32'h0,        0,0, "r0_after_write"};
        tbl[3]  = '{1,1,0,32'hDEAD,       0,0,0,32'h0,  0,0,0,  0,0,1,0,  32'h0,        32'hDEAD,     0,0, "b1r0_bypass"};
        tbl[4]  = '{0,0,0,32'h0,          0,0,0,32'h0,  0,0,0,  1,0,0,0,  32'hDEAD,     32'h0,        0,0, "b1r0_stored"};
        tbl[5]  = '{1,0,7,32'h11,         1,0,7,32'h22, 0,0,0,  0,7,0,7,  32'h22,       32'h22,       0,0, "dual_write_bypass"};
        tbl[6]  = '{0,0,0,32'h0,          0,0,0,32'h0,  0,0,0,  0,7,1,7,  32'h22,       32'h0,        0,0, "dual_write_stored"};
        tbl[7]  = '{0,0,0,32'h0,          0,0,0,32'h0,  1,1,3,  1,3,1,3,  32'h0,        32'h0,        0,0, "rsv_same_cycle"};
        tbl[8]  = '{0,0,0,32'h0,          0,0,0,32'h0,  0,0,0,  1,3,1,3,  32'h0,        32'h0,        1,1, "rsv_visible"};
        tbl[9]  = '{0,0,0,32'h0,          1,1,3,32'h33, 0,0,0,  1,3,0,3,  32'h33,       32'h0,        0,0, "write_clears_pend"};
        tbl[10] = '{0,0,0,32'h0,          0,0,0,32'h0,  0,0,0,  1,3,1,3,  32'h33,       32'h33,       0,0, "pend_cleared"};
        tbl[11] = '{1,1,3,32'h44,         0,0,0,32'h0,  1,1,3,  1,3,1,3,  32'h44,       32'h44,       0,0, "rsv_write_same"};
        tbl[12] = '{0,0,0,32'h0,          0,0,0,32'h0,  0,0,0,  1,3,1,3,  32'h44,       32'h44,       1,1, "new_producer_wins"};
        tbl[13] = '{0,0,0,32'h0,          0,0,0,32'h0,  1,0,0,  0,0,1,3,  32'h0,        32'h44,       0,1, "rsv_r0"};
        tbl[14] = '{0,0,0,32'h0,          0,0,0,32'h0,  0,0,0,  0,0,1,3,  32'h0,        32'h44,       0,1, "r0_never_pending"};
        tbl[15] = '{1,0,5,32'h55,         0,0,0,32'h0,  0,0,0,  1,5,0,5,  32'h0,        32'h55,       0,0, "no_bank_alias"};

        idle();
        #1 reset = 1'b0;
        @(negedge clock);
        check("reset_busy", {31'b0, clr_busy}, 32'd0);
        check("reset_done", {31'b0, clr_done}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        for (int k = 0; k < 16; k++) begin
            v = tbl[k];
            if (v.we0) setWr(0, v.wb0, v.wa0, v.wd0);
            if (v.we1) setWr(1, v.wb1, v.wa1, v.wd1);
            if (v.rsv) setRsv(v.rsb, v.rsa);
            setRd(0, v.rb0, v.ra0);
            setRd(1, v.rb1, v.ra1);
            expRd(0, v.e0, {v.name, "_rd0"});
            expRd(1, v.e1, {v.name, "_rd1"});
            expPend(0, v.p0, {v.name, "_pend0"});
            expPend(1, v.p1, {v.name, "_pend1"});
            step();
        end

        // Fill bank 0, then reserve r4 so the clear must drop its pending bit
        for (int a = 1; a < 32; a += 2) begin
            setWr(0, 0, a, 32'hA000 + a);
            if (a + 1 < 32) setWr(1, 0, a + 1, 32'hA000 + a + 1);
            step();
        end
        setRsv(0, 4);
        setRd(0, 0, 4); setRd(1, 0, 31);
        expRd(0, 32'hA004, "fill_r4"); expRd(1, 32'hA01F, "fill_r31");
        step();
        setRd(0, 0, 4);
        expPend(0, 1'b1, "fill_r4_pend");
        clr_req = 1'b1; clr_bank = 1'b0;
        #4;
        check("clr_idle_busy", {31'b0, clr_busy}, 32'd0);
        drain();
        @(posedge clock); @(negedge clock); idle();

        busyCnt = 0;
        doneCnt = 0;
        for (int c = 0; c < 80; c++) begin
            if (c < 20) begin
                setWr(0, 1, c, 32'hB000 + c);
                setWr(1, 0, 9, 32'hBAD);
                setRsv(0, 9);
                clr_req = 1'b1; clr_bank = 1'b1;
                setRd(0, 0, 9); setRd(1, 0, 2);
                expRd(0, 32'h0, "clr_read_r9");
                expRd(1, 32'd256, "clr_read_sp");
            end
            #4;
            if (clr_busy) busyCnt++;
            if (clr_done) doneCnt++;
            drain();
            @(posedge clock); @(negedge clock); idle();
            if (!clr_busy) break;
        end
        check("clr_busy_cycles", busyCnt, 32'd33);
        check("clr_done_pulses", doneCnt, 32'd1);

        for (int a = 0; a < 32; a += 2) begin
            setRd(0, 0, a); setRd(1, 0, a + 1);
            expRd(0, (a == 2) ? 32'd256 : 32'h0, "post_clr_b0_even");
            expRd(1, 32'h0, "post_clr_b0_odd");
            expPend(0, 1'b0, "post_clr_pend_even");
            expPend(1, 1'b0, "post_clr_pend_odd");
            step();
        end
        for (int a = 0; a < 20; a += 2) begin
            setRd(0, 1, a); setRd(1, 1, a + 1);
            expRd(0, 32'hB000 + a, "b1_kept_even");
            expRd(1, 32'hB000 + a + 1, "b1_kept_odd");
            step();
        end

        // Reset in the middle of a clear
        setWr(0, 0, 2, 32'h77); setWr(1, 0, 10, 32'h99); setRsv(1, 5);
        step();
        setRd(0, 1, 5); setRd(1, 0, 10);
        expPend(0, 1'b1, "pre_rst_pend_b1r5");
        expRd(1, 32'h99, "pre_rst_b0r10");
        clr_req = 1'b1; clr_bank = 1'b0;
        step();
        for (int k = 0; k < 10; k++) step();
        check("busy_before_reset", {31'b0, clr_busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("reset_mid_clr_busy", {31'b0, clr_busy}, 32'd0);
        check("reset_mid_clr_done", {31'b0, clr_done}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        idle();
        setRd(0, 0, 2); setRd(1, 0, 10);
        expRd(0, 32'd256, "rst_b0_sp");
        expRd(1, 32'h0, "rst_b0r10");
        step();
        check("rst_fsm_idle", {31'b0, clr_busy}, 32'd0);
        setRd(0, 1, 4); setRd(1, 1, 5);
        expRd(0, 32'h0, "rst_b1r4");
        expPend(1, 1'b0, "rst_pend_b1r5");
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
